serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 168 ++++++++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Operands are captured on an accepted
// start, then one full-adder cell consumes one bit per clock, LSB first. The
// registered sum/cout only update when the last bit completes, so partial
// results never appear on the outputs.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sr_reg, a_sr_next;
    logic [WIDTH-1:0]   b_sr_reg, b_sr_next;
    logic [WIDTH-1:0]   psum_reg, psum_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
    logic               cout_reg, cout_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    // Control strobes decoded from the current state.
    logic accept;     // start taken this edge (IDLE or DONE only)
    logic step;       // one bit is processed this edge
    logic last_step;  // this edge processes the MSB and completes the result

    // Full-adder cell on the current LSBs.
    logic s_bit;
    logic c_maj;

    // Right-shifted views of the shift registers; the partial-sum view
    // already carries the new bit in its MSB.
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] psum_shift;

    assign s_bit = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
    assign c_maj = (a_sr_reg[0] & b_sr_reg[0])
                 | (a_sr_reg[0] & carry_reg)
                 | (b_sr_reg[0] & carry_reg);

    // Per-bit shift wiring: operands shift zeros in at the top, the partial
    // sum shifts the freshly computed bit in at the top.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bits
            if (gi == WIDTH - 1) begin : g_top
                assign a_shift[gi]    = 1'b0;
                assign b_shift[gi]    = 1'b0;
                assign psum_shift[gi] = s_bit;
            end else begin : g_low
                assign a_shift[gi]    = a_sr_reg[gi+1];
                assign b_shift[gi]    = b_sr_reg[gi+1];
                assign psum_shift[gi] = psum_reg[gi+1];
            end
        end
    endgenerate

    // Next-state and output decode; start is only honoured outside RUN.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    last_step  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: load on accept, shift on each RUN step,
    // publish the result only on the final step.
    always_comb begin
        a_sr_next  = a_sr_reg;
        b_sr_next  = b_sr_reg;
        psum_next  = psum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        if (accept) begin
            a_sr_next  = a;
            b_sr_next  = b;
            psum_next  = '0;
            carry_next = cin;
            cnt_next   = '0;
        end else if (step) begin
            a_sr_next  = a_shift;
            b_sr_next  = b_shift;
            psum_next  = psum_shift;
            carry_next = c_maj;
            cnt_next   = last_step ? '0 : cnt_reg + 1'b1;
            if (last_step) begin
                sum_next  = psum_shift;
                cout_next = c_maj;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_sr_reg  <= a_sr_next;
            b_sr_reg  <= b_sr_next;
            psum_reg  <= psum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table vectors, hand-written corner sequences, an exhaustive
// sweep and randomized operations checked against plain a+b+cin arithmetic.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_sum;
    logic         held_cout;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] vsum;
        logic         vcout;
    } vec_t;

    vec_t vecs[7];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer addition, split into truncated sum and carry.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output logic [W-1:0] s, output logic co);
        int total;
        total = int'(x) + int'(y) + int'(c);
        s  = W'(total % (1 << W));
        co = (total >= (1 << W));
    endtask

    // One complete operation from the accepting edge to the done cycle.
    // perturb scrambles a/b/cin and toggles start while the adder runs.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic [W-1:0] es, input logic ec, input bit perturb);
        a = x; b = y; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_sum_hold", 32'(sum), 32'(held_sum));
            check("run_cout_hold", 32'(cout), 32'(held_cout));
            if (perturb) begin
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom);
            end
            tick();
        end
        start = 1'b0;
        check("res_done", 32'(done), 32'd1);
        check("res_busy", 32'(busy), 32'd0);
        check("res_sum", 32'(sum), 32'(es));
        check("res_cout", 32'(cout), 32'(ec));
        $display("op a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d (exp %0d/%0d)",
                 x, y, c, sum, cout, es, ec);
        held_sum  = es;
        held_cout = ec;
    endtask

    // One idle cycle after a done: DONE must fall back to IDLE and hold results.
    task automatic idle_check();
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sum", 32'(sum), 32'(held_sum));
        check("idle_cout", 32'(cout), 32'(held_cout));
    endtask

    initial begin
        logic [W-1:0] ms;
        logic         mc;
        int           n;
        int           pulses;
        logic [W-1:0] seen_sum;
        logic         seen_cout;

        vecs[0] = '{4'd3,  4'd5,  1'b0, 4'd8,  1'b0};
        vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0};
        vecs[5] = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1};
        vecs[6] = '{4'd6,  4'd9,  1'b0, 4'd15, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1; a = 4'd5; b = 4'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        tick();
        check("rst_prio_busy2", 32'(busy), 32'd0);
        check("rst_prio_done", 32'(done), 32'd0);

        // Table-driven vectors, each followed by an idle cycle.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsum, vecs[i].vcout, 1'b0);
            idle_check();
        end

        // Start mid-RUN is ignored: a single done with the first operands.
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0; seen_sum = '1; seen_cout = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                a = 4'd9; b = 4'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                seen_sum = sum;
                seen_cout = cout;
            end
            tick();
        end
        start = 1'b0;
        check("ignore_pulses", 32'(pulses), 32'd1);
        check("ignore_sum", 32'(seen_sum), 32'd4);
        check("ignore_cout", 32'(seen_cout), 32'd0);
        $display("op a=2 b=2 cin=0 (start again mid-run) -> pulses=%0d sum=%0d", pulses, seen_sum);
        held_sum = 4'd4; held_cout = 1'b0;

        // Back-to-back: start during the done cycle.
        run_op(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b0);
        a = 4'd7; b = 4'd8; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_gap", 32'(n), 32'd5);
        check("b2b_sum", 32'(sum), 32'd0);
        check("b2b_cout", 32'(cout), 32'd1);
        $display("op a=7 b=8 cin=1 back-to-back -> gap=%0d sum=%0d cout=%0d", n, sum, cout);
        held_sum = 4'd0; held_cout = 1'b1;
        idle_check();

        // Reset in the second RUN cycle aborts with no done pulse.
        run_op(4'd9, 4'd3, 1'b0, 4'd12, 1'b0, 1'b0);
        idle_check();
        a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        $display("op a=5 b=6 aborted by reset -> busy=%0d sum=%0d", busy, sum);
        held_sum = '0; held_cout = 1'b0;

        // First start after reset behaves normally.
        run_op(4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b0);
        idle_check();

        // Exhaustive sweep, run back-to-back.
        for (int ai = 0; ai < (1 << W); ai++) begin
            for (int bi = 0; bi < (1 << W); bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    model(W'(ai), W'(bi), 1'(ci), ms, mc);
                    run_op(W'(ai), W'(bi), 1'(ci), ms, mc, 1'b0);
                end
            end
        end
        idle_check();

        // Randomized operations with input churn and spurious starts while running.
        for (int r = 0; r < 60; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            int           gap;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, ms, mc);
            run_op(ra, rb, rc, ms, mc, 1'b1);
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
